// File: rtl/audio_pkg.sv
// audio_pkg: shared types for the I2S ADC capture path.
//   state_t       - capture FSM states
//   chan_t        - channel currently being shifted (left/right)
//   DATA_W_DEF    - default sample width, matches the codec IWL setting
//   sample_pair_t - one stereo sample pair
package audio_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_SKIP  = 3'd2,
    S_SHIFT = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] left;
    logic [DATA_W_DEF-1:0] right;
  } sample_pair_t;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: multi-stage synchronizer for one asynchronous pin plus
// single-cycle rise/fall pulses on the synchronized level.
// Ports:
//   i_clk, i_rst_n - system clock, synchronous active-low reset
//   i_async        - asynchronous input pin
//   o_sync         - synchronized level
//   o_rise/o_fall  - one-cycle pulses when o_sync goes 0->1 / 1->0
module edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;

  // synchronizer chain and one-cycle history of the synchronized level
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], i_async};
      prev_r <= sync_r[SYNC_STAGES-1];
    end
  end

  assign o_sync = sync_r[SYNC_STAGES-1];
  assign o_rise = sync_r[SYNC_STAGES-1] & ~prev_r;
  assign o_fall = ~sync_r[SYNC_STAGES-1] & prev_r;

endmodule

// File: rtl/audio_i2s_capture.sv
// audio_i2s_capture: deserializes a WM8731 master-mode I2S ADC stream
// (oversampled in the system clock domain) into stereo sample pairs and
// offers them over a valid/ready handshake with a one-deep output register.
// Ports:
//   i_clk, i_rst_n          - system clock (>= 4x BCLK), sync active-low reset
//   i_init_done, i_enable   - capture runs only while both are high
//   i_aud_bclk/lrck/adcdat  - asynchronous codec pins
//   o_left, o_right         - captured pair (two's complement)
//   o_valid, i_ready        - output handshake
//   o_overrun               - sticky: a completed pair was dropped
//   o_busy                  - FSM outside S_IDLE
// Build option: define I2S_CAP_MONO_EN to add o_mono, the floor average
// of left and right, registered with the pair.
module audio_i2s_capture
  import audio_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_init_done,
  input  logic              i_enable,
  input  logic              i_aud_bclk,
  input  logic              i_aud_lrck,
  input  logic              i_aud_adcdat,
  output logic [DATA_W-1:0] o_left,
  output logic [DATA_W-1:0] o_right,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_overrun,
`ifdef I2S_CAP_MONO_EN
  output logic [DATA_W-1:0] o_mono,
`endif
  output logic              o_busy
);

  localparam int               CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic bclk_rise_s, bclk_sync_unused_s, bclk_fall_unused_s;
  logic lrck_rise_s, lrck_fall_s, lrck_sync_unused_s;
  logic adcdat_s, adcdat_rise_unused_s, adcdat_fall_unused_s;

  state_t            state_r, next_state_s;
  chan_t             chan_r, next_chan_s;
  logic [DATA_W-1:0] shift_r, hold_r, shift_next_s;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic              run_s, lrck_edge_s, shift_en_s, word_done_s, pair_done_s, load_s;
  logic [DATA_W-1:0] left_r, right_r;
  logic              valid_r, overrun_r, busy_r;

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bclk_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_aud_bclk),
    .o_sync(bclk_sync_unused_s), .o_rise(bclk_rise_s), .o_fall(bclk_fall_unused_s)
  );

  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lrck_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_aud_lrck),
    .o_sync(lrck_sync_unused_s), .o_rise(lrck_rise_s), .o_fall(lrck_fall_s)
  );

  // ADCDAT only needs the level; its edge pulses are left dangling.
  edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_adcdat_sync (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_async(i_aud_adcdat),
    .o_sync(adcdat_s), .o_rise(adcdat_rise_unused_s), .o_fall(adcdat_fall_unused_s)
  );

  assign run_s        = i_init_done & i_enable;
  assign lrck_edge_s  = lrck_rise_s | lrck_fall_s;
  // An LRCK edge in the same cycle as a BCLK edge wins: the word is short.
  assign shift_en_s   = run_s & (state_r == S_SHIFT) & bclk_rise_s & ~lrck_edge_s;
  assign shift_next_s = {shift_r[DATA_W-2:0], adcdat_s};
  assign word_done_s  = shift_en_s & (bit_cnt_r == LAST_BIT);
  assign pair_done_s  = word_done_s & (chan_r == CH_RIGHT);
  assign load_s       = pair_done_s & (~valid_r | i_ready);

  // next-state logic for the framing FSM
  always_comb begin
    next_state_s = state_r;
    next_chan_s  = chan_r;
    if (!run_s) begin
      next_state_s = S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: next_state_s = S_ALIGN;
        S_ALIGN: begin
          if (lrck_fall_s) begin
            next_state_s = S_SKIP;
            next_chan_s  = CH_LEFT;
          end else begin
            next_state_s = S_ALIGN;
          end
        end
        S_SKIP: begin
          if (lrck_edge_s) begin
            next_state_s = S_ALIGN;
          end else if (bclk_rise_s) begin
            next_state_s = S_SHIFT;
          end else begin
            next_state_s = S_SKIP;
          end
        end
        S_SHIFT: begin
          if (lrck_edge_s) begin
            next_state_s = S_ALIGN;
          end else if (word_done_s) begin
            next_state_s = S_WAIT;
          end else begin
            next_state_s = S_SHIFT;
          end
        end
        S_WAIT: begin
          if (lrck_rise_s) begin
            next_state_s = S_SKIP;
            next_chan_s  = CH_RIGHT;
          end else if (lrck_fall_s) begin
            next_state_s = S_SKIP;
            next_chan_s  = CH_LEFT;
          end else begin
            next_state_s = S_WAIT;
          end
        end
        default: next_state_s = S_IDLE;
      endcase
    end
  end

  // FSM state, channel and busy registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r <= S_IDLE;
      chan_r  <= CH_LEFT;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      chan_r  <= next_chan_s;
      busy_r  <= (next_state_s != S_IDLE);
    end
  end

  // shift register, bit counter and left holding register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      shift_r   <= {DATA_W{1'b0}};
      bit_cnt_r <= {CNT_W{1'b0}};
      hold_r    <= {DATA_W{1'b0}};
    end else begin
      if (shift_en_s) begin
        shift_r   <= shift_next_s;
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
      end else if (state_r != S_SHIFT) begin
        bit_cnt_r <= {CNT_W{1'b0}};
      end
      if (word_done_s && (chan_r == CH_LEFT)) begin
        hold_r <= shift_next_s;
      end
    end
  end

  // one-deep output register with handshake and sticky overrun
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      left_r    <= {DATA_W{1'b0}};
      right_r   <= {DATA_W{1'b0}};
      valid_r   <= 1'b0;
      overrun_r <= 1'b0;
    end else begin
      if (load_s) begin
        left_r  <= hold_r;
        right_r <= shift_next_s;
        valid_r <= 1'b1;
      end else if (valid_r && i_ready) begin
        valid_r <= 1'b0;
      end
      if (!i_enable) begin
        overrun_r <= 1'b0;
      end else if (pair_done_s && !load_s) begin
        overrun_r <= 1'b1;
      end
    end
  end

`ifdef I2S_CAP_MONO_EN
  logic [DATA_W:0]   mono_sum_s;
  logic [DATA_W-1:0] mono_r;

  // Sign-extended sum; dropping bit 0 is the arithmetic shift, which
  // floors and always fits back into DATA_W bits.
  assign mono_sum_s = {hold_r[DATA_W-1], hold_r} + {shift_next_s[DATA_W-1], shift_next_s};

  // mono average register, loaded with the pair
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mono_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
      mono_r <= mono_sum_s[DATA_W:1];
    end
  end

  assign o_mono = mono_r;
`endif

  assign o_left    = left_r;
  assign o_right   = right_r;
  assign o_valid   = valid_r;
  assign o_overrun = overrun_r;
  assign o_busy    = busy_r;

endmodule

// File: tb/tb_audio_i2s_capture.sv
// Testbench for audio_i2s_capture: drives an I2S codec model at BCLK = clk/8
// and checks every accepted pair against an in-order queue of expected pairs.
module tb_audio_i2s_capture;
  import audio_pkg::*;

  typedef struct {
    sample_pair_t pair;
    logic [15:0]  mono;
  } exp_t;

  typedef struct {
    logic [15:0] l, r;
    logic [15:0] exp_l, exp_r, exp_mono;
  } vec_t;

  logic clk, rst_n, init_done, enable, bclk, lrck, adcdat, ready, rand_ready;
  logic [15:0] dut_left, dut_right;
  logic dut_valid, dut_overrun, dut_busy;
`ifdef I2S_CAP_MONO_EN
  logic [15:0] dut_mono;
`endif

  int compared = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  vec_t tbl[8];

  audio_i2s_capture #(.DATA_W(16), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_init_done(init_done), .i_enable(enable),
    .i_aud_bclk(bclk), .i_aud_lrck(lrck), .i_aud_adcdat(adcdat),
    .o_left(dut_left), .o_right(dut_right), .o_valid(dut_valid),
    .i_ready(ready), .o_overrun(dut_overrun),
`ifdef I2S_CAP_MONO_EN
    .o_mono(dut_mono),
`endif
    .o_busy(dut_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Reference: floor((left + right) / 2) on signed integers.
  function automatic exp_t make_exp(input logic [15:0] l, input logic [15:0] r);
    exp_t e;
    int a, b, s;
    a = $signed(l);
    b = $signed(r);
    s = a + b;
    e.pair.left  = l;
    e.pair.right = r;
    e.mono       = 16'(s >>> 1);
    return e;
  endfunction

  // Consumer side: inputs are settled here and hold through the next posedge.
  task automatic monitor_step();
    exp_t e;
    if (dut_valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_pair: got %h/%h, want none", dut_left, dut_right);
      end else begin
        e = exp_q.pop_front();
        check("pair_left", 32'(dut_left), 32'(e.pair.left));
        check("pair_right", 32'(dut_right), 32'(e.pair.right));
`ifdef I2S_CAP_MONO_EN
        check("pair_mono", 32'(dut_mono), 32'(e.mono));
`endif
      end
    end
  endtask

  task automatic tick();
    monitor_step();
    @(negedge clk);
    #2;
  endtask

  task automatic tick_r();
    if (rand_ready) ready = 1'($urandom());
    tick();
  endtask

  // One BCLK period: data and LRCK change on the falling edge.
  task automatic bclk_cycle(input logic d, input logic lr);
    bclk = 1'b0; lrck = lr; adcdat = d;
    repeat (4) tick_r();
    bclk = 1'b1;
    repeat (4) tick_r();
  endtask

  task automatic send_half(input logic lr, input logic [15:0] w, input int nbits, input int pad);
    bclk_cycle(1'($urandom()), lr);
    for (int i = 0; i < nbits; i++) bclk_cycle(w[15-i], lr);
    for (int i = 0; i < pad; i++) bclk_cycle(1'($urandom()), lr);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int pad);
    send_half(1'b0, l, 16, pad);
    send_half(1'b1, r, 16, pad);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [15:0] lw, rw;
    int lat;

    tbl[0] = '{16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 16'hFFFF};
    tbl[1] = '{16'h7FFF, 16'h0001, 16'h7FFF, 16'h0001, 16'h4000};
    tbl[2] = '{16'h8000, 16'hFFFF, 16'h8000, 16'hFFFF, 16'hBFFF};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[4] = '{16'h1234, 16'h0002, 16'h1234, 16'h0002, 16'h091B};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[6] = '{16'h0003, 16'h0000, 16'h0003, 16'h0000, 16'h0001};
    tbl[7] = '{16'hFFFD, 16'h0000, 16'hFFFD, 16'h0000, 16'hFFFE};

    rst_n = 1'b0; init_done = 1'b0; enable = 1'b1; ready = 1'b1;
    bclk = 1'b0; lrck = 1'b1; adcdat = 1'b0; rand_ready = 1'b0;
    repeat (3) tick();
    check("reset_valid", 32'(dut_valid), 32'd0);
    check("reset_busy", 32'(dut_busy), 32'd0);
    check("reset_overrun", 32'(dut_overrun), 32'd0);
    check("reset_left", 32'(dut_left), 32'd0);
    check("reset_right", 32'(dut_right), 32'd0);

    // Start gating on init_done
    rst_n = 1'b1;
    repeat (100) tick();
    check("idle_busy", 32'(dut_busy), 32'd0);
    check("idle_valid", 32'(dut_valid), 32'd0);
    init_done = 1'b1;
    tick();
    check("start_busy", 32'(dut_busy), 32'd1);

    // Basic capture with latency measured from the right LSB BCLK edge
    lw = 16'h8001; rw = 16'h7FFE;
    exp_q.push_back(make_exp(lw, rw));
    send_half(1'b0, lw, 16, 0);
    bclk_cycle(1'b0, 1'b1);
    for (int i = 0; i < 15; i++) bclk_cycle(rw[15-i], 1'b1);
    bclk = 1'b0; lrck = 1'b1; adcdat = rw[0];
    repeat (4) tick();
    bclk = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (dut_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    check("valid_latency", 32'(lat), 32'd3);
    tick();
    drain("basic_drain");

    // Table of fixed vectors, including the mono rounding corners
    for (int i = 0; i < 8; i++) begin
      e.pair.left  = tbl[i].exp_l;
      e.pair.right = tbl[i].exp_r;
      e.mono       = tbl[i].exp_mono;
      exp_q.push_back(e);
      send_frame(tbl[i].l, tbl[i].r, i % 3);
    end
    drain("table_drain");

    // Enable arrives mid right word: that frame must not appear
    enable = 1'b0;
    repeat (4) tick();
    send_half(1'b0, 16'hDEAD, 16, 0);
    bclk_cycle(1'b0, 1'b1);
    rw = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) enable = 1'b1;
      bclk_cycle(rw[15-i], 1'b1);
    end
    check("midenable_no_valid", 32'(dut_valid), 32'd0);
    exp_q.push_back(make_exp(16'h2468, 16'hA5A5));
    send_frame(16'h2468, 16'hA5A5, 1);
    drain("midenable_drain");

    // Backpressure: A held, B dropped, overrun sticky until enable drops
    repeat (4) tick();
    ready = 1'b0;
    send_frame(16'h1111, 16'h2222, 0);
    send_frame(16'h3333, 16'h4444, 0);
    repeat (4) tick();
    check("bp_valid", 32'(dut_valid), 32'd1);
    check("bp_overrun", 32'(dut_overrun), 32'd1);
    check("bp_left_held", 32'(dut_left), 32'h1111);
    check("bp_right_held", 32'(dut_right), 32'h2222);
    exp_q.push_back(make_exp(16'h1111, 16'h2222));
    ready = 1'b1;
    repeat (4) tick();
    check("bp_accept", 32'(exp_q.size()), 32'd0);
    check("bp_valid_low", 32'(dut_valid), 32'd0);
    check("bp_overrun_sticky", 32'(dut_overrun), 32'd1);
    enable = 1'b0;
    tick();
    check("bp_overrun_clear", 32'(dut_overrun), 32'd0);
    check("disable_busy", 32'(dut_busy), 32'd0);
    enable = 1'b1;
    tick();

    // Short left word (10 bits) is discarded, next frame is captured
    send_half(1'b0, 16'hBEEF, 10, 0);
    send_half(1'b1, 16'hCAFE, 16, 0);
    check("short_no_valid", 32'(dut_valid), 32'd0);
    exp_q.push_back(make_exp(16'h0F0F, 16'hF0F0));
    send_frame(16'h0F0F, 16'hF0F0, 2);
    drain("short_drain");

    // Randomized frames with random consumer stalls
    rand_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      lw = 16'($urandom());
      rw = 16'($urandom());
      exp_q.push_back(make_exp(lw, rw));
      send_frame(lw, rw, $urandom_range(0, 3));
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    drain("random_drain");
    check("random_overrun", 32'(dut_overrun), 32'd0);

    // Reset mid-frame with a pending pair
    ready = 1'b0;
    send_frame(16'h5555, 16'h6666, 0);
    repeat (4) tick();
    check("pending_valid", 32'(dut_valid), 32'd1);
    bclk_cycle(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) bclk_cycle(1'b1, 1'b0);
    rst_n = 1'b0;
    repeat (2) tick();
    check("midreset_valid", 32'(dut_valid), 32'd0);
    check("midreset_busy", 32'(dut_busy), 32'd0);
    check("midreset_left", 32'(dut_left), 32'd0);
    check("midreset_right", 32'(dut_right), 32'd0);
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    check("restart_busy", 32'(dut_busy), 32'd1);
    send_half(1'b1, 16'h9999, 16, 0);
    exp_q.push_back(make_exp(16'h7777, 16'h8888));
    send_frame(16'h7777, 16'h8888, 0);
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
